decoding_stage_controller: RTL and testbench
============================================

# decoding_stage_controller

Sequences the array of Z-type union-find processing units through one decoding round. Drives the shared `global_stage` bus and accepts a measurement round through a valid/ready handshake. Alternates GROW and MERGE phases until no odd cluster remains, using the OR-reduced `busy` and `odd` outputs of every unit to decide when to stop. Then hands a completion record to the downstream peeling and result logic through a second handshake.

## Interface
- `PE_COUNT`, 64: number of processing units observed.
- `STAGE_WIDTH`, 3: width of the stage bus.
- `BUSY_LATENCY`, 2: MERGE cycles during which `busy_any` is ignored (1-cycle stage register in the units plus the registered `busy`).
- `MAX_MERGE_CYCLES`, 255: MERGE cycles allowed before a timeout; 8-bit counter.
- `MAX_GROW_ROUNDS`, 63: GROW/MERGE iterations allowed before an overflow; 8-bit counter.
- `PEEL_CYCLES`, 4: cycles held in PEELING.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low; all state clears while it is 0.
- `meas_valid` in 1: a measurement round is present on the units' `measurement` inputs.
- `meas_ready` out 1: controller accepts a round; high only in IDLE.
- `busy` in PE_COUNT: per-unit busy.
- `odd` in PE_COUNT: per-unit odd.
- `global_stage` out STAGE_WIDTH: stage broadcast to all units.
- `result_valid` out 1: round complete; the outputs below are stable.
- `result_ready` in 1: downstream has consumed the result.
- `grow_rounds` out 8: GROW phases executed in the round.
- `error` out 1: a merge timeout or grow overflow occurred in the round.

## Operation
Stage encodings: IDLE=0, GROW=1, MERGE=2, PEELING=3, RESULT_VALID=4, MEASUREMENT_LOADING=5. The FSM state is `global_stage` itself, driven from a register.

- `busy_any = |busy` and `odd_any = |odd`, both combinational from the unit outputs.
- **IDLE**
  - `meas_ready` = 1.
  - When `meas_valid` is 1, go to MEASUREMENT_LOADING.
  - On entry to MEASUREMENT_LOADING, clear `grow_rounds` and `error`.
- **MEASUREMENT_LOADING**: exactly 1 cycle, then GROW.
- **GROW**
  - Exactly 1 cycle.
  - Increments `grow_rounds`, saturating at 255.
  - Next state is MERGE.
  - The units generate their growth pulse from the first GROW cycle of a run, so back-to-back GROW cycles are forbidden.
- **MERGE**
  - Merge counter `mc` is cleared on entry and incremented every MERGE cycle, saturating.
  - Exit condition: `mc >= BUSY_LATENCY` and `busy_any == 0`.
    - If `odd_any == 1` and `grow_rounds < MAX_GROW_ROUNDS`: go to GROW.
    - If `odd_any == 1` and `grow_rounds == MAX_GROW_ROUNDS`: set `error`, go to PEELING.
    - If `odd_any == 0`: go to PEELING.
  - Timeout: if `mc == MAX_MERGE_CYCLES` and the exit condition is false, set `error` and go to PEELING.
- **PEELING**: held exactly `PEEL_CYCLES` cycles (reuses the `mc` counter), then RESULT_VALID.
- **RESULT_VALID**
  - `result_valid` = 1; `grow_rounds` and `error` are held.
  - When `result_ready` is 1, go to IDLE.
  - `grow_rounds` and `error` keep their values until the next MEASUREMENT_LOADING.
- Simultaneous `meas_valid` and `result_ready` cannot conflict, because `meas_ready` and `result_valid` are never both high.
- `reset` asserted in any state: the FSM returns to IDLE asynchronously. Any partly decoded round is discarded with no result emitted.

## Timing
- Reset values:
  - `global_stage` = IDLE
  - `meas_ready` = 1
  - `result_valid` = 0
  - `grow_rounds` = 0
  - `error` = 0
  - `mc` = 0
- All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- Handshake latency: `meas_valid` sampled high at edge N gives MEASUREMENT_LOADING in cycle N+1 and GROW in cycle N+2.
- Minimum MERGE length is `BUSY_LATENCY+1` cycles.
- Minimum round, from acceptance to `result_valid`, is 1+1+3+`PEEL_CYCLES` = 9 cycles with defaults.
- `busy_any` must be sampled only while `mc >= BUSY_LATENCY`. A high `busy` during the first `BUSY_LATENCY` MERGE cycles is ignored.
- `odd_any` is sampled only in the MERGE exit cycle. It is then valid because no unit is busy.

## Test plan
- **Idle handshake**: hold `meas_valid`=0 for 10 cycles -> `global_stage` stays 0 and `meas_ready`=1. Then pulse `meas_valid` -> stage sequence 5, 1, 2.
- **Trivial round**: `busy`=0 and `odd`=0 throughout -> stages 5, 1, 2, 2, 2, 3×4, 4; `grow_rounds`=1 and `error`=0.
  - Hold `result_ready`=0 for 5 cycles -> `result_valid` stays 1 and the stage stays 4.
  - Then assert `result_ready` -> back to IDLE.
- **Multi-round convergence**:
  - Unit 7 drives `odd`=1 for the first two MERGE exits, then 0.
  - Unit 3 holds `busy`=1 for 4 cycles of each MERGE.
  - Expect three GROW cycles, each MERGE lasting 5 cycles, and `grow_rounds`=3.
- **Latency mask**: `busy`=1 only during MERGE cycles 0-1 -> MERGE lasts exactly 3 cycles.
- **Timeout and overflow**:
  - `busy` stuck at 1 -> PEELING after 256 MERGE cycles, `error`=1.
  - Separately, `odd` stuck at 1 with `MAX_GROW_ROUNDS`=3 -> PEELING after the 3rd MERGE, `grow_rounds`=3, `error`=1.
- **Reset mid-round**: drive `reset` to 0 in the 2nd MERGE cycle -> `global_stage`=0, `grow_rounds`=0 and `meas_ready`=1 without waiting for a clock edge. A new round after release completes normally.

Source files
------------

// File: rtl/decoding_stage_controller.sv
// Round sequencer for the union-find unit array: IDLE -> LOAD -> (GROW -> MERGE)* -> PEELING -> RESULT_VALID.
// Latency: accept at edge N, LOAD in N+1, GROW in N+2; minimum round to result_valid is 9 cycles.
// Backpressure: meas_ready only in IDLE; result held in RESULT_VALID until result_ready.
module decoding_stage_controller #(
  parameter int PE_COUNT         = 64,
  parameter int STAGE_WIDTH      = 3,
  parameter int BUSY_LATENCY     = 2,
  parameter int MAX_MERGE_CYCLES = 255,
  parameter int MAX_GROW_ROUNDS  = 63,
  parameter int PEEL_CYCLES      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   meas_valid,
  output logic                   meas_ready,
  input  logic [PE_COUNT-1:0]    busy,
  input  logic [PE_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [7:0]             grow_rounds,
  output logic                   error
);

  localparam logic [STAGE_WIDTH-1:0] ST_IDLE  = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] ST_GROW  = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] ST_MERGE = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] ST_PEEL  = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] ST_RV    = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] ST_LOAD  = STAGE_WIDTH'(5);

  logic [STAGE_WIDTH-1:0] r_stage;
  logic [7:0]             r_mc;
  logic [7:0]             r_grow_rounds;
  logic                   r_error;

  logic [STAGE_WIDTH-1:0] w_stage_nxt;
  logic [7:0]             w_mc_nxt;
  logic [7:0]             w_grow_nxt;
  logic                   w_error_nxt;
  logic                   w_busy_any;
  logic                   w_odd_any;
  logic                   w_merge_done;

  assign w_busy_any   = |busy;
  assign w_odd_any    = |odd;
  // busy is only trusted once the units have seen the MERGE stage and re-registered busy
  assign w_merge_done = (r_mc >= 8'(BUSY_LATENCY)) && !w_busy_any;

  assign global_stage = r_stage;
  assign meas_ready   = (r_stage == ST_IDLE);
  assign result_valid = (r_stage == ST_RV);
  assign grow_rounds  = r_grow_rounds;
  assign error        = r_error;

  // next-state, merge/peel counter and round-result bookkeeping
  always_comb begin
    w_stage_nxt = r_stage;
    w_mc_nxt    = r_mc;
    w_grow_nxt  = r_grow_rounds;
    w_error_nxt = r_error;
    case (r_stage)
      ST_IDLE: begin
        if (meas_valid) begin
          w_stage_nxt = ST_LOAD;
          w_grow_nxt  = 8'd0;
          w_error_nxt = 1'b0;
        end
      end
      ST_LOAD: w_stage_nxt = ST_GROW;
      ST_GROW: begin
        // single GROW cycle: units pulse growth on the first GROW cycle of a run
        w_stage_nxt = ST_MERGE;
        w_mc_nxt    = 8'd0;
        if (r_grow_rounds != 8'hFF) w_grow_nxt = r_grow_rounds + 8'd1;
      end
      ST_MERGE: begin
        if (r_mc != 8'hFF) w_mc_nxt = r_mc + 8'd1;
        if (w_merge_done) begin
          if (w_odd_any && (r_grow_rounds < 8'(MAX_GROW_ROUNDS))) begin
            w_stage_nxt = ST_GROW;
          end else begin
            if (w_odd_any) w_error_nxt = 1'b1;
            w_stage_nxt = ST_PEEL;
            w_mc_nxt    = 8'd0;
          end
        end else if (r_mc == 8'(MAX_MERGE_CYCLES)) begin
          w_error_nxt = 1'b1;
          w_stage_nxt = ST_PEEL;
          w_mc_nxt    = 8'd0;
        end
      end
      ST_PEEL: begin
        if (r_mc == 8'(PEEL_CYCLES - 1)) w_stage_nxt = ST_RV;
        else                             w_mc_nxt    = r_mc + 8'd1;
      end
      ST_RV: begin
        if (result_ready) w_stage_nxt = ST_IDLE;
      end
      default: w_stage_nxt = ST_IDLE;
    endcase
  end

  // state registers; reset discards any in-flight round
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage       <= ST_IDLE;
      r_mc          <= 8'd0;
      r_grow_rounds <= 8'd0;
      r_error       <= 1'b0;
    end else begin
      r_stage       <= w_stage_nxt;
      r_mc          <= w_mc_nxt;
      r_grow_rounds <= w_grow_nxt;
      r_error       <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_decoding_stage_controller.sv
// Randomized bench: a round description (per-MERGE busy hold length, odd at exit) is expanded
// into an expected per-cycle stage trace plus final grow_rounds/error, then replayed on the DUT.
// Inputs that the controller must ignore in a given cycle are driven with random values.
module tb_decoding_stage_controller;

  localparam int PE   = 64;
  localparam int MAXG = 3;
  localparam int PEEL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          meas_valid;
  logic          meas_ready;
  logic [PE-1:0] busy;
  logic [PE-1:0] odd;
  logic [2:0]    global_stage;
  logic          result_valid;
  logic          result_ready;
  logic [7:0]    grow_rounds;
  logic          error;

  always #5 clk = ~clk;

  decoding_stage_controller #(
    .PE_COUNT(PE), .STAGE_WIDTH(3), .BUSY_LATENCY(2), .MAX_MERGE_CYCLES(255),
    .MAX_GROW_ROUNDS(MAXG), .PEEL_CYCLES(PEEL)
  ) dut (
    .clk(clk), .reset(reset), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .busy(busy), .odd(odd), .global_stage(global_stage), .result_valid(result_valid),
    .result_ready(result_ready), .grow_rounds(grow_rounds), .error(error)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // round description and the expanded expectation
  int            q_busy[$];
  bit            q_odd[$];
  int            exp_q[$];
  logic [PE-1:0] bq[$];
  logic [PE-1:0] oq[$];
  int            exp_gr;
  int            exp_err;

  function automatic logic [PE-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [PE-1:0] some_set();
    return rnd64() | (64'd1 << $urandom_range(PE - 1, 0));
  endfunction

  task automatic push(input int s, input logic [PE-1:0] b, input logic [PE-1:0] o);
    exp_q.push_back(s);
    bq.push_back(b);
    oq.push_back(o);
  endtask

  // expand the round description into the cycle-by-cycle expectation
  task automatic build_round();
    int  k;
    int  b;
    int  last;
    bit  o;
    bit  done;
    exp_q.delete(); bq.delete(); oq.delete();
    exp_gr = 0; exp_err = 0; k = 0; done = 0;
    push(5, rnd64(), rnd64());
    while (!done) begin
      push(1, rnd64(), rnd64());
      if (exp_gr < 255) exp_gr++;
      b = (k < q_busy.size()) ? q_busy[k] : 0;
      o = (k < q_odd.size()) ? q_odd[k] : 1'b0;
      k++;
      // the first two MERGE cycles never end a merge; afterwards it ends once busy drops
      last = (b > 2) ? b : 2;
      if (last > 255) begin
        for (int m = 0; m < 256; m++) push(2, some_set(), rnd64());
        exp_err = 1;
        done    = 1;
      end else begin
        for (int m = 0; m <= last; m++)
          push(2, (m < b) ? some_set() : ((m < 2) ? rnd64() : '0),
                  (m == last) ? (o ? some_set() : '0) : rnd64());
        if (!(o && exp_gr < MAXG)) begin
          if (o) exp_err = 1;
          done = 1;
        end
      end
    end
    for (int p = 0; p < PEEL; p++) push(3, rnd64(), rnd64());
  endtask

  // replay one round from IDLE; entered and left at #1 after a rising edge
  task automatic run_round(input int rv_wait);
    build_round();
    check("idle_stage", 32'(global_stage), 0);
    check("idle_meas_ready", 32'(meas_ready), 1);
    meas_valid = 1'b1; busy = rnd64(); odd = rnd64(); result_ready = 1'($urandom);
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check("stage", 32'(global_stage), exp_q[i]);
      check("meas_ready_low", 32'(meas_ready), 0);
      check("result_valid_low", 32'(result_valid), 0);
      busy = bq[i]; odd = oq[i];
      meas_valid = 1'($urandom); result_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    for (int i = 0; i <= rv_wait; i++) begin
      check("rv_stage", 32'(global_stage), 4);
      check("result_valid", 32'(result_valid), 1);
      check("grow_rounds", 32'(grow_rounds), exp_gr);
      check("error", 32'(error), exp_err);
      result_ready = (i == rv_wait);
      meas_valid = 1'($urandom); busy = rnd64(); odd = rnd64();
      @(posedge clk); #1;
    end
    meas_valid = 1'b0; result_ready = 1'b0;
    check("back_idle", 32'(global_stage), 0);
    check("held_grow_rounds", 32'(grow_rounds), exp_gr);
    check("held_error", 32'(error), exp_err);
  endtask

  task automatic set_round1(input int b, input bit o);
    q_busy.delete(); q_odd.delete();
    q_busy.push_back(b); q_odd.push_back(o);
  endtask

  initial begin
    reset = 1'b0; meas_valid = 1'b0; result_ready = 1'b0; busy = '0; odd = '0;
    #12;
    check("rst_stage", 32'(global_stage), 0);
    check("rst_meas_ready", 32'(meas_ready), 1);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_grow_rounds", 32'(grow_rounds), 0);
    check("rst_error", 32'(error), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // idle holds with no request
    for (int i = 0; i < 10; i++) begin
      busy = rnd64(); odd = rnd64(); result_ready = 1'($urandom);
      check("idle_hold_stage", 32'(global_stage), 0);
      check("idle_hold_ready", 32'(meas_ready), 1);
      @(posedge clk); #1;
    end
    result_ready = 1'b0;

    // trivial round with result held 5 cycles
    set_round1(0, 1'b0);
    run_round(5);

    // multi-round convergence: 4 busy cycles per merge, odd on first two exits
    q_busy.delete(); q_odd.delete();
    q_busy = '{4, 4, 4}; q_odd = '{1'b1, 1'b1, 1'b0};
    run_round(1);

    // busy only in the masked first two merge cycles
    set_round1(2, 1'b0);
    run_round(0);

    // stuck busy -> merge timeout
    set_round1(1000, 1'b0);
    run_round(2);

    // busy drops exactly at the last allowed merge cycle
    set_round1(255, 1'b0);
    run_round(0);

    // stuck odd -> grow overflow
    q_busy.delete(); q_odd.delete();
    q_odd = '{1'b1, 1'b1, 1'b1};
    run_round(0);

    // reset in the 2nd MERGE cycle
    meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = 1'b0; busy = '1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_stage", 32'(global_stage), 2);
    check("pre_reset_grow_rounds", 32'(grow_rounds), 1);
    reset = 1'b0;
    #1;
    check("async_rst_stage", 32'(global_stage), 0);
    check("async_rst_grow_rounds", 32'(grow_rounds), 0);
    check("async_rst_meas_ready", 32'(meas_ready), 1);
    check("async_rst_result_valid", 32'(result_valid), 0);
    busy = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    set_round1(0, 1'b0);
    run_round(0);

    // random rounds
    for (int r = 0; r < 30; r++) begin
      int nm;
      q_busy.delete(); q_odd.delete();
      nm = $urandom_range(3, 1);
      for (int j = 0; j < nm; j++) begin
        q_busy.push_back(($urandom_range(19, 0) == 0) ? 256 + $urandom_range(10, 0)
                                                      : $urandom_range(7, 0));
        q_odd.push_back(1'($urandom));
      end
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        busy = rnd64(); odd = rnd64();
        check("gap_stage", 32'(global_stage), 0);
        @(posedge clk); #1;
      end
      run_round($urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
